// File: rtl/tri_pkg.sv
// Shared definitions for the triangle job dispatcher: FSM states and default data width.
package tri_pkg;

  localparam int TRI_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } tri_state_e;

endpackage

// File: rtl/tri_dispatch_if.sv
// Bundle of the dispatcher's input stream, core handshake, result stream and status.
interface tri_dispatch_if
  import tri_pkg::*;
#(
  parameter int WIDTH = TRI_WIDTH,
  parameter int DEPTH = 4
) ();

  logic                       s_valid;
  logic                       s_ready;
  logic [WIDTH-1:0]           s_data;
  logic                       core_go;
  logic [WIDTH-1:0]           core_in0;
  logic [WIDTH-1:0]           core_out0;
  logic                       core_done;
  logic                       m_valid;
  logic                       m_ready;
  logic [WIDTH-1:0]           m_data;
  logic                       m_err;
  logic                       busy;
  logic [$clog2(DEPTH):0]     count;

  // Dispatcher side.
  modport slave (
    input  s_valid, s_data, core_out0, core_done, m_ready,
    output s_ready, core_go, core_in0, m_valid, m_data, m_err, busy, count
  );

  // Producer / core / consumer side.
  modport master (
    output s_valid, s_data, core_out0, core_done, m_ready,
    input  s_ready, core_go, core_in0, m_valid, m_data, m_err, busy, count
  );

endinterface

// File: rtl/tri_fifo.sv
// Synchronous FIFO holding queued jobs; head is the oldest entry, valid when !empty.
module tri_fifo
  import tri_pkg::*;
#(
  parameter int WIDTH = TRI_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; entries are only read back once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tri_dispatch.sv
// Issues queued jobs one at a time to the triangle core and returns results in order,
// substituting an error result when the core fails to answer within TIMEOUT cycles.
module tri_dispatch
  import tri_pkg::*;
#(
  parameter int WIDTH   = TRI_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input logic           clk,
  input logic           reset,
  tri_dispatch_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  tri_state_e       state_q, state_d;
  logic             go_q, go_d;
  logic [WIDTH-1:0] in0_q, in0_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_err_q, m_err_d;

  logic             res_free;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] fifo_head;

  // Ready comes from registered occupancy only, so a same-cycle pop never admits a push at full.
  assign bus.s_ready = reset && !fifo_full;
  assign fifo_push   = bus.s_valid && bus.s_ready;

  tri_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.s_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_comb begin
    state_d   = state_q;
    go_d      = go_q;
    in0_d     = in0_q;
    timer_d   = timer_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    fifo_pop  = 1'b0;
    res_free  = !m_valid_q || bus.m_ready;

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && res_free) begin
          fifo_pop = 1'b1;
          in0_d    = fifo_head;
          go_d     = 1'b1;
          timer_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (TIMEOUT != 0) timer_d = timer_q + 1'b1;
        // Completion takes priority over a coincident watchdog expiry.
        if (bus.core_done) begin
          m_data_d  = bus.core_out0;
          m_err_d   = 1'b0;
          m_valid_d = 1'b1;
          go_d      = 1'b0;
          state_d   = GAP;
        end else if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
          m_data_d  = '0;
          m_err_d   = 1'b1;
          m_valid_d = 1'b1;
          go_d      = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        // Wait out a held done level so it is never taken as the next job's completion.
        if (!bus.core_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      in0_q     <= '0;
      timer_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      in0_q     <= in0_d;
      timer_q   <= timer_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_err_q   <= m_err_d;
    end
  end

  assign bus.core_go  = go_q;
  assign bus.core_in0 = in0_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_err    = m_err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.count    = fifo_count;

endmodule

// File: tb/tb_tri_dispatch.sv
// Directed bench for tri_dispatch with a behavioural triangle core and an in-order result scoreboard.
module tb_tri_dispatch;
  import tri_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tri_dispatch_if #(.WIDTH(W), .DEPTH(D)) bus ();

  tri_dispatch #(
    .WIDTH   (W),
    .DEPTH   (D),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   hang = 1'b0;
  int   hold_len = 0;
  int   cyc = 0;
  int   hold = 0;

  function automatic logic [W-1:0] tri_val(input int n);
    return W'(n * (n + 1) / 2);
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Core model: result n(n+1)/2, done rises n+2 cycles after go, optionally held after go drops.
  always @(posedge clk) begin
    if (!reset) begin
      cyc           <= 0;
      hold          <= 0;
      bus.core_done <= 1'b0;
      bus.core_out0 <= '0;
    end else if (bus.core_go) begin
      cyc           <= cyc + 1;
      bus.core_out0 <= tri_val(int'(bus.core_in0));
      if (!hang && cyc + 1 >= int'(bus.core_in0) + 2) begin
        bus.core_done <= 1'b1;
        hold          <= hold_len;
      end
    end else begin
      cyc <= 0;
      if (hold > 1) hold <= hold - 1;
      else begin
        hold          <= 0;
        bus.core_done <= 1'b0;
      end
    end
  end

  // Result monitor: a transfer completes at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin : mon
    res_t got;
    res_t exp;
    if (reset && bus.m_valid && bus.m_ready) begin
      got = {bus.m_err, bus.m_data};
      exp = 'x;
      if (sb.size() != 0) exp = sb.pop_front();
      chk("result", (W+1)'(got), (W+1)'(exp));
    end
  end

  task automatic push(input int n, input bit err_exp, input bit track);
    int   t;
    res_t r;
    t = 0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = W'(n);
    while (!bus.s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("push_accept", (W+1)'(t < 400), 1);
    if (track) begin
      r.err  = err_exp;
      r.data = err_exp ? '0 : tri_val(n);
      sb.push_back(r);
    end
    @(posedge clk);
    #1 bus.s_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.m_ready = v;
  endtask

  task automatic wait_go(input logic lvl, input string tag);
    int t;
    t = 0;
    while (bus.core_go !== lvl && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (W+1)'(t < 400), 1);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk(tag, (W+1)'(sb.size()), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",  (W+1)'(bus.s_ready), 0);
    chk("rst_core_go",  (W+1)'(bus.core_go), 0);
    chk("rst_core_in0", (W+1)'(bus.core_in0), 0);
    chk("rst_m_valid",  (W+1)'(bus.m_valid), 0);
    chk("rst_m_data",   (W+1)'(bus.m_data), 0);
    chk("rst_m_err",    (W+1)'(bus.m_err), 0);
    chk("rst_busy",     (W+1)'(bus.busy), 0);
    chk("rst_count",    (W+1)'(bus.count), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_s_ready",  (W+1)'(bus.s_ready), 1);

    // Single job with exact push-to-go latency.
    set_ready(1'b1);
    push(5, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_count_after_push", (W+1)'(bus.count), 1);
    chk("t1_go_not_yet",       (W+1)'(bus.core_go), 0);
    @(negedge clk);
    chk("t1_go",    (W+1)'(bus.core_go), 1);
    chk("t1_in0",   (W+1)'(bus.core_in0), 5);
    chk("t1_busy",  (W+1)'(bus.busy), 1);
    chk("t1_count", (W+1)'(bus.count), 0);
    drain("t1_drain");
    repeat (3) @(negedge clk);
    chk("t1_busy_fall", (W+1)'(bus.busy), 0);

    // Burst fills the FIFO while the first job runs.
    push(1, 1'b0, 1'b1);
    push(2, 1'b0, 1'b1);
    push(3, 1'b0, 1'b1);
    push(10, 1'b0, 1'b1);
    push(11, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_count_full", (W+1)'(bus.count), 4);
    chk("t2_s_ready_lo", (W+1)'(bus.s_ready), 0);
    cnt = 0;
    while (!bus.s_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t2_count_after_pop", (W+1)'(bus.count), 3);
    drain("t2_drain");

    // Backpressure holds the result and blocks the next issue.
    set_ready(1'b0);
    push(5, 1'b0, 1'b1);
    push(2, 1'b0, 1'b1);
    cnt = 0;
    while (!bus.m_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    repeat (10) @(negedge clk);
    chk("t3_m_valid_held", (W+1)'(bus.m_valid), 1);
    chk("t3_m_data_held",  (W+1)'(bus.m_data), 15);
    chk("t3_m_err_held",   (W+1)'(bus.m_err), 0);
    chk("t3_no_go",        (W+1)'(bus.core_go), 0);
    chk("t3_count",        (W+1)'(bus.count), 1);
    set_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("t3_issue_same_cycle", (W+1)'(bus.core_go), 1);
    chk("t3_issue_in0",        (W+1)'(bus.core_in0), 2);
    drain("t3_drain");

    // Watchdog: a hung core yields an error result after exactly TIMEOUT go cycles.
    @(posedge clk);
    #1 hang = 1'b1;
    push(7, 1'b1, 1'b1);
    push(4, 1'b0, 1'b1);
    @(negedge clk);
    wait_go(1'b1, "t4_go_rise");
    cnt = 0;
    while (bus.core_go === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    hang = 1'b0;
    chk("t4_go_cycles", (W+1)'(cnt), TO);
    chk("t4_m_valid",   (W+1)'(bus.m_valid), 1);
    chk("t4_m_err",     (W+1)'(bus.m_err), 1);
    chk("t4_m_data",    (W+1)'(bus.m_data), 0);
    drain("t4_drain");

    // Reset during a running job discards it.
    push(9, 1'b0, 1'b0);
    @(negedge clk);
    wait_go(1'b1, "t5_go_rise");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_go",      (W+1)'(bus.core_go), 0);
    chk("t5_m_valid", (W+1)'(bus.m_valid), 0);
    chk("t5_count",   (W+1)'(bus.count), 0);
    chk("t5_busy",    (W+1)'(bus.busy), 0);
    chk("t5_s_ready", (W+1)'(bus.s_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    push(4, 1'b0, 1'b1);
    drain("t5_drain");

    // Held done keeps the FSM in GAP and delays the next go.
    hold_len = 5;
    push(3, 1'b0, 1'b1);
    push(2, 1'b0, 1'b1);
    @(negedge clk);
    wait_go(1'b1, "t6_go_rise");
    wait_go(1'b0, "t6_go_fall");
    cnt = 0;
    while (bus.core_go === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("t6_gap_cycles",  (W+1)'(cnt), 7);
    chk("t6_done_low_at_go", (W+1)'(bus.core_done), 0);
    drain("t6_drain");
    hold_len = 0;

    repeat (20) @(negedge clk);
    chk("final_sb_empty", (W+1)'(sb.size()), 0);
    chk("final_idle",     (W+1)'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
